cim_cmd_issuer: RTL and testbench

Host-side command sequencer that drives the M4BRAM CIM-mode write port (cim_en, in_clear, data, byte_en) so that the in-BRAM control FSM runs a complete multi-chunk dot product. It accepts a job descriptor and a stream of 32-bit activation words, and emits the exact cycle-by-cycle instruction stream the in-BRAM FSM expects: configure, start, copy, idle compute cycles and done. It then holds a readout window until the host acknowledges and finally resets the in-BRAM FSM. It sits between the accelerator controller and each M4BRAM's byte-enable/data write port.

---
 rtl/cim_cmd_issuer.sv | 197 +++++++++++++++++++
 tb/tb_cim_cmd_issuer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_cmd_issuer.sv
// cim_cmd_issuer: sequences the M4BRAM CIM-mode write port through a full
// multi-chunk dot product (configure, start, copies, compute, done, reset).
// Ports:
//   clk, reset                    clock, async active-high reset
//   job_valid/job_ready           job descriptor handshake
//   job_sign, job_prec_m1,
//   job_nchunk_m1                 job descriptor fields
//   act_valid/act_ready, act_data activation word stream (2-entry FIFO)
//   cim_en, in_clear, data,
//   byte_en                       BRAM CIM-mode write port (registered)
//   rd_valid/rd_ack               accumulator readout window handshake
//   busy, err_underrun            status
module cim_cmd_issuer (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic        job_sign,
    input  logic [2:0]  job_prec_m1,
    input  logic [7:0]  job_nchunk_m1,
    input  logic        act_valid,
    output logic        act_ready,
    input  logic [31:0] act_data,
    output logic        cim_en,
    output logic        in_clear,
    output logic [31:0] data,
    output logic [3:0]  byte_en,
    output logic        rd_valid,
    input  logic        rd_ack,
    output logic        busy,
    output logic        err_underrun
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_START,
        S_LOAD1,
        S_LOAD2,
        S_RUN,
        S_ADD,
        S_ACC,
        S_DONE,
        S_RST
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [7:0]  nchunk_q;
    logic [3:0]  run_last_q;
    logic [3:0]  run_last_new;
    logic [7:0]  chunk;
    logic [3:0]  cyc;

    logic [31:0] fifo_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        accept;
    logic        push;
    logic        pop;
    logic        copy_nxt;
    logic        last_chunk;

    assign job_ready  = (state == S_IDLE) && (count == 2'd2);
    assign act_ready  = (count != 2'd2);
    assign accept     = job_valid && job_ready;
    assign push       = act_valid && act_ready;
    assign last_chunk = (chunk == nchunk_q);
    // A copy cycle with an empty FIFO is still issued, just without a pop.
    assign pop        = copy_nxt && (count != 2'd0);

    // Index of the final RUN cycle, i.e. L-3.
    always_comb begin
        run_last_new = 4'd1;
        if (job_sign) begin
            if (job_prec_m1 == 3'd0)
                run_last_new = 4'd2;
            else
                run_last_new = {1'b0, job_prec_m1} + 4'd1;
        end else begin
            if (job_prec_m1 == 3'd0)
                run_last_new = 4'd1;
            else
                run_last_new = {1'b0, job_prec_m1};
        end
    end

    // Next-state decode; copy_nxt flags that the next cycle is a copy cycle.
    always_comb begin
        nxt      = state;
        copy_nxt = 1'b0;
        unique case (state)
            S_IDLE:  if (accept) nxt = S_CFG;
            S_CFG:   nxt = S_START;
            S_START: begin
                nxt      = S_LOAD1;
                copy_nxt = 1'b1;
            end
            S_LOAD1: begin
                nxt      = S_LOAD2;
                copy_nxt = 1'b1;
            end
            S_LOAD2: nxt = S_RUN;
            S_RUN: begin
                if (cyc == run_last_q) begin
                    nxt      = S_ADD;
                    copy_nxt = !last_chunk;
                end
            end
            S_ADD: begin
                nxt      = S_ACC;
                copy_nxt = !last_chunk;
            end
            S_ACC:   nxt = last_chunk ? S_DONE : S_RUN;
            S_DONE:  if (rd_ack) nxt = S_RST;
            S_RST:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // FSM with outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cim_en       <= 1'b0;
            in_clear     <= 1'b0;
            data         <= '0;
            byte_en      <= '0;
            rd_valid     <= 1'b0;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
            nchunk_q     <= '0;
            run_last_q   <= '0;
            chunk        <= '0;
            cyc          <= '0;
        end else begin
            state    <= nxt;
            cim_en   <= (nxt != S_IDLE);
            busy     <= (nxt != S_IDLE);
            in_clear <= (nxt == S_CFG);
            rd_valid <= (nxt == S_DONE);
            data     <= pop ? fifo_mem[rd_ptr] : '0;

            unique case (nxt)
                S_CFG:   byte_en <= {job_sign, job_prec_m1};
                S_START: byte_en <= 4'b0100;
                S_LOAD1: byte_en <= 4'b0010;
                S_LOAD2: byte_en <= 4'b0010;
                S_ADD:   byte_en <= last_chunk ? 4'b0000 : 4'b0010;
                S_ACC:   byte_en <= last_chunk ? 4'b0001 : 4'b0010;
                S_RST:   byte_en <= 4'b1000;
                default: byte_en <= 4'b0000;
            endcase

            if (accept) begin
                nchunk_q     <= job_nchunk_m1;
                run_last_q   <= run_last_new;
                err_underrun <= 1'b0;
            end else if (copy_nxt && (count == 2'd0)) begin
                err_underrun <= 1'b1;
            end

            if (state == S_RUN && nxt == S_RUN)
                cyc <= cyc + 4'd1;
            else
                cyc <= '0;

            if (accept)
                chunk <= '0;
            else if (state == S_ACC && nxt == S_RUN)
                chunk <= chunk + 8'd1;
        end
    end

    // Activation FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= act_data;
    end

endmodule

// File: tb/tb_cim_cmd_issuer.sv
// tb_cim_cmd_issuer: scoreboard bench for cim_cmd_issuer. Expected port
// cycles are queued at job acceptance; a negedge monitor pops and compares.
module tb_cim_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic        job_sign;
    logic [2:0]  job_prec_m1;
    logic [7:0]  job_nchunk_m1;
    logic        act_valid;
    logic        act_ready;
    logic [31:0] act_data;
    logic        cim_en;
    logic        in_clear;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic        rd_valid;
    logic        rd_ack;
    logic        busy;
    logic        err_underrun;

    cim_cmd_issuer dut (
        .clk           (clk),
        .reset         (reset),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_sign      (job_sign),
        .job_prec_m1   (job_prec_m1),
        .job_nchunk_m1 (job_nchunk_m1),
        .act_valid     (act_valid),
        .act_ready     (act_ready),
        .act_data      (act_data),
        .cim_en        (cim_en),
        .in_clear      (in_clear),
        .data          (data),
        .byte_en       (byte_en),
        .rd_valid      (rd_valid),
        .rd_ack        (rd_ack),
        .busy          (busy),
        .err_underrun  (err_underrun)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        logic        ic;
        logic [3:0]  be;
        logic [31:0] d;
        logic        rv;
        logic        eu;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] wl [8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic ic, input logic [3:0] be,
                            input logic [31:0] d, input logic rv,
                            input logic eu);
        exp_t e;
        e.cyc = c;
        e.ic  = ic;
        e.be  = be;
        e.d   = d;
        e.rv  = rv;
        e.eu  = eu;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with cim_en high must match the queue head.
    always @(negedge clk) begin
        if (cim_en) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_cmd: got be=%b at cycle %0d expected none",
                         byte_en, cyc_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cycle",    64'(cyc_n),    64'(e.cyc));
                check("in_clear", 64'(in_clear), 64'(e.ic));
                check("byte_en",  64'(byte_en),  64'(e.be));
                check("data",     64'(data),     64'(e.d));
                check("rd_valid", 64'(rd_valid), 64'(e.rv));
                check("err",      64'(err_underrun), 64'(e.eu));
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        int t;
        t = 0;
        @(negedge clk);
        while (!act_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("push_wait", 64'(act_ready), 64'd1);
        if (act_ready) begin
            act_data  = w;
            act_valid = 1'b1;
            @(posedge clk);
            #1;
            act_valid = 1'b0;
        end
    endtask

    task automatic wait_job_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!job_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("job_ready_wait", 64'(job_ready), 64'd1);
    endtask

    // Accepts a job, queues its expected port sequence, then acknowledges
    // the readout after d_cyc DONE cycles. Words come from wl.
    task automatic run_job(input logic sgn, input logic [2:0] pm1,
                           input logic [7:0] nm1, input int len,
                           input int d_cyc, input int exp_rd,
                           input int ur_k, input bit want_ready);
        int e0;
        int n;
        int base;
        int t;
        logic eu;
        wait_job_ready();
        job_sign      = sgn;
        job_prec_m1   = pm1;
        job_nchunk_m1 = nm1;
        job_valid     = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        e0 = cyc_n;
        n  = int'(nm1) + 1;
        push_exp(e0,     1'b1, {sgn, pm1}, 32'd0, 1'b0, 1'b0);
        push_exp(e0 + 1, 1'b0, 4'b0100,    32'd0, 1'b0, 1'b0);
        push_exp(e0 + 2, 1'b0, 4'b0010,    wl[0], 1'b0, 1'b0);
        push_exp(e0 + 3, 1'b0, 4'b0010,    wl[1], 1'b0, 1'b0);
        for (int c = 0; c < n; c++) begin
            base = 5 + c * len;
            for (int k = base; k < base + len - 2; k++) begin
                eu = (ur_k != 0) && (k >= ur_k);
                push_exp(e0 + k - 1, 1'b0, 4'b0000, 32'd0, 1'b0, eu);
            end
            for (int j = 0; j < 2; j++) begin
                int k;
                k  = base + len - 2 + j;
                eu = (ur_k != 0) && (k >= ur_k);
                if (c < n - 1)
                    push_exp(e0 + k - 1, 1'b0, 4'b0010, wl[2 + 2 * c + j],
                             1'b0, eu);
                else
                    push_exp(e0 + k - 1, 1'b0, (j == 0) ? 4'b0000 : 4'b0001,
                             32'd0, 1'b0, eu);
            end
        end
        eu = (ur_k != 0);
        for (int k = 0; k < d_cyc; k++)
            push_exp(e0 + exp_rd + k - 1, 1'b0, 4'b0000, 32'd0, 1'b1, eu);
        push_exp(e0 + exp_rd + d_cyc - 1, 1'b0, 4'b1000, 32'd0, 1'b0, eu);

        t = 0;
        @(negedge clk);
        while (!rd_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rd_valid_cycle", 64'(cyc_n - e0 + 1), 64'(exp_rd));
        repeat (d_cyc - 1) @(negedge clk);
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
        t = 0;
        @(negedge clk);
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1;
        check("idle_after_rst", 64'(cim_en), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        if (want_ready)
            check("job_ready_after", 64'(job_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e0;
        reset         = 1'b1;
        job_valid     = 1'b0;
        job_sign      = 1'b0;
        job_prec_m1   = 3'd0;
        job_nchunk_m1 = 8'd0;
        act_valid     = 1'b0;
        act_data      = 32'd0;
        rd_ack        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cim_en",   64'(cim_en),       64'd0);
        check("rst_in_clear", 64'(in_clear),     64'd0);
        check("rst_data",     64'(data),         64'd0);
        check("rst_byte_en",  64'(byte_en),      64'd0);
        check("rst_rd_valid", 64'(rd_valid),     64'd0);
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_err",      64'(err_underrun), 64'd0);
        check("rst_job_rdy",  64'(job_ready),    64'd0);
        check("rst_act_rdy",  64'(act_ready),    64'd1);
        reset = 1'b0;

        // Unsigned p=4, N=1: L=6, rd_valid at 11.
        wl = '{32'hA1A2A3A4, 32'hB1B2B3B4, 0, 0, 0, 0, 0, 0};
        push_word(wl[0]);
        check("one_word_no_job", 64'(job_ready), 64'd0);
        push_word(wl[1]);
        run_job(1'b0, 3'd3, 8'd0, 6, 1, 11, 0, 1'b0);

        // Signed p=8, N=3: L=11, rd_valid at 38, stray ack during RUN.
        wl = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004,
               32'h50000005, 32'h60000006, 0, 0};
        push_word(wl[0]);
        push_word(wl[1]);
        fork
            begin
                push_word(wl[2]);
                push_word(wl[3]);
                push_word(wl[4]);
                push_word(wl[5]);
            end
            run_job(1'b1, 3'd7, 8'd2, 11, 1, 38, 0, 1'b0);
            begin
                repeat (10) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join

        // Signed p=1, N=1: L=5, rd_valid at 10, held 5 cycles.
        wl = '{32'hC0C0C0C0, 32'hC1C1C1C1, 0, 0, 0, 0, 0, 0};
        push_word(wl[0]);
        push_word(wl[1]);
        fork
            run_job(1'b1, 3'd0, 8'd0, 5, 5, 10, 0, 1'b1);
            begin
                repeat (12) @(negedge clk);
                push_word(32'hD0D0D0D0);
                push_word(32'hD1D1D1D1);
            end
        join

        // Unsigned p=2, N=2, no further words: underrun from cycle 7.
        wl = '{32'hD0D0D0D0, 32'hD1D1D1D1, 0, 0, 0, 0, 0, 0};
        run_job(1'b0, 3'd1, 8'd1, 4, 2, 13, 7, 1'b0);
        check("err_sticky_idle", 64'(err_underrun), 64'd1);

        // Reset during RUN.
        push_word(32'hE0E0E0E0);
        push_word(32'hE1E1E1E1);
        wait_job_ready();
        job_sign      = 1'b1;
        job_prec_m1   = 3'd7;
        job_nchunk_m1 = 8'd0;
        job_valid     = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        e0 = cyc_n;
        push_exp(e0,     1'b1, 4'b1111, 32'd0,        1'b0, 1'b0);
        push_exp(e0 + 1, 1'b0, 4'b0100, 32'd0,        1'b0, 1'b0);
        push_exp(e0 + 2, 1'b0, 4'b0010, 32'hE0E0E0E0, 1'b0, 1'b0);
        push_exp(e0 + 3, 1'b0, 4'b0010, 32'hE1E1E1E1, 1'b0, 1'b0);
        push_exp(e0 + 4, 1'b0, 4'b0000, 32'd0,        1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_cim_en",  64'(cim_en),    64'd0);
        check("mid_byte_en", 64'(byte_en),   64'd0);
        check("mid_busy",    64'(busy),      64'd0);
        check("mid_act_rdy", 64'(act_ready), 64'd1);
        check("mid_job_rdy", 64'(job_ready), 64'd0);
        check("mid_rd_val",  64'(rd_valid),  64'd0);
        check("mid_sb",      64'(sb.size()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wl = '{32'hF0F0F0F0, 32'hF1F1F1F1, 0, 0, 0, 0, 0, 0};
        push_word(wl[0]);
        check("post_rst_one", 64'(job_ready), 64'd0);
        push_word(wl[1]);
        check("post_rst_two", 64'(job_ready), 64'd1);

        // Unsigned p=1, N=1: L=4, rd_valid at 9.
        run_job(1'b0, 3'd0, 8'd0, 4, 1, 9, 0, 1'b0);

        check("final_sb", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
